// File: rtl/calc_alu_arbiter.sv
// Round-robin sharing of a single start/done calculator ALU among NREQ requesters.
// Optional build macro CALC_ARB_DIV0_CHECK_EN: div/mod by zero answered locally (all-ones, error).
module calc_alu_arbiter #(
    parameter int NREQ    = 4,
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [3*NREQ-1:0]     req_op,
    input  logic [WIDTH*NREQ-1:0] req_a,
    input  logic [WIDTH*NREQ-1:0] req_b,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       rsp_valid,
    output logic [WIDTH-1:0]      rsp_result,
    output logic                  rsp_err,
    output logic                  busy,
    output logic                  alu_start,
    output logic [2:0]            alu_op,
    output logic [WIDTH-1:0]      alu_op1,
    output logic [WIDTH-1:0]      alu_op2,
    input  logic                  alu_done,
    input  logic [WIDTH-1:0]      alu_result
);
    localparam int PW = $clog2(NREQ);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0]   CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [NREQ-1:0] ONE_HOT0 = {{(NREQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [PW-1:0]     owner_q, owner_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [NREQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic              err_q, err_d;
    logic [2:0]        op_q, op_d;
    logic [WIDTH-1:0]  op1_q, op1_d;
    logic [WIDTH-1:0]  op2_q, op2_d;
    logic              start_q, start_d;
    logic              busy_q;

    logic              sel_found_s;
    logic [PW-1:0]     sel_idx_s;
    logic [PW-1:0]     cand_s;
    logic [2:0]        sel_op_s;
    logic [WIDTH-1:0]  sel_a_s;
    logic [WIDTH-1:0]  sel_b_s;
    logic              sel_div0_s;
    logic              timeout_s;

    // Round-robin pick: first pending request at or after the pointer, wrapping around.
    always_comb begin
        sel_found_s = 1'b0;
        sel_idx_s   = {PW{1'b0}};
        cand_s      = {PW{1'b0}};
        for (int k = 0; k < NREQ; k++) begin
            cand_s = PW'((int'(ptr_q) + k) % NREQ);
            if (!sel_found_s && req[cand_s]) begin
                sel_found_s = 1'b1;
                sel_idx_s   = cand_s;
            end else begin
                sel_found_s = sel_found_s;
            end
        end
    end

    // Operand mux for the selected requester.
    always_comb begin
        sel_op_s = 3'b000;
        sel_a_s  = {WIDTH{1'b0}};
        sel_b_s  = {WIDTH{1'b0}};
        for (int i = 0; i < NREQ; i++) begin
            if (PW'(i) == sel_idx_s) begin
                sel_op_s = req_op[3*i +: 3];
                sel_a_s  = req_a[WIDTH*i +: WIDTH];
                sel_b_s  = req_b[WIDTH*i +: WIDTH];
            end else begin
                sel_op_s = sel_op_s;
            end
        end
    end

`ifdef CALC_ARB_DIV0_CHECK_EN
    assign sel_div0_s = ((sel_op_s == 3'b011) || (sel_op_s == 3'b100)) &&
                        (sel_b_s == {WIDTH{1'b0}});
`else
    assign sel_div0_s = 1'b0;
`endif

    // The counter runs across ISSUE and WAIT, so a stuck sticky done is also bounded.
    assign timeout_s = (cnt_q >= CNT_LAST);

    // Next-state, grant/response pulses and operand latching.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        cnt_d       = cnt_q;
        gnt_d       = {NREQ{1'b0}};
        rsp_valid_d = {NREQ{1'b0}};
        result_d    = result_q;
        err_d       = err_q;
        op_d        = op_q;
        op1_d       = op1_q;
        op2_d       = op2_q;
        start_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (sel_found_s) begin
                    owner_d = sel_idx_s;
                    ptr_d   = PW'((int'(sel_idx_s) + 1) % NREQ);
                    op_d    = sel_op_s;
                    op1_d   = sel_a_s;
                    op2_d   = sel_b_s;
                    gnt_d   = ONE_HOT0 << sel_idx_s;
                    cnt_d   = {CW{1'b0}};
                    if (sel_div0_s) begin
                        state_d     = S_RESP;
                        result_d    = {WIDTH{1'b1}};
                        err_d       = 1'b1;
                        rsp_valid_d = ONE_HOT0 << sel_idx_s;
                    end else begin
                        state_d = S_ISSUE;
                        start_d = 1'b1;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                cnt_d = cnt_q + CNT_ONE;
                // A low done means the ALU has taken start and cleared its stale result.
                if (!alu_done) begin
                    state_d = S_WAIT;
                end else if (timeout_s) begin
                    state_d     = S_RESP;
                    result_d    = {WIDTH{1'b0}};
                    err_d       = 1'b1;
                    rsp_valid_d = ONE_HOT0 << owner_q;
                end else begin
                    start_d = 1'b1;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q + CNT_ONE;
                if (alu_done) begin
                    state_d     = S_RESP;
                    result_d    = alu_result;
                    err_d       = 1'b0;
                    rsp_valid_d = ONE_HOT0 << owner_q;
                end else if (timeout_s) begin
                    state_d     = S_RESP;
                    result_d    = {WIDTH{1'b0}};
                    err_d       = 1'b1;
                    rsp_valid_d = ONE_HOT0 << owner_q;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            ptr_q       <= {PW{1'b0}};
            owner_q     <= {PW{1'b0}};
            cnt_q       <= {CW{1'b0}};
            gnt_q       <= {NREQ{1'b0}};
            rsp_valid_q <= {NREQ{1'b0}};
            result_q    <= {WIDTH{1'b0}};
            err_q       <= 1'b0;
            op_q        <= 3'b000;
            op1_q       <= {WIDTH{1'b0}};
            op2_q       <= {WIDTH{1'b0}};
            start_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            cnt_q       <= cnt_d;
            gnt_q       <= gnt_d;
            rsp_valid_q <= rsp_valid_d;
            result_q    <= result_d;
            err_q       <= err_d;
            op_q        <= op_d;
            op1_q       <= op1_d;
            op2_q       <= op2_d;
            start_q     <= start_d;
            busy_q      <= (state_d != S_IDLE);
        end
    end

    assign gnt        = gnt_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = result_q;
    assign rsp_err    = err_q;
    assign busy       = busy_q;
    assign alu_start  = start_q;
    assign alu_op     = op_q;
    assign alu_op1    = op1_q;
    assign alu_op2    = op2_q;

endmodule

// File: tb/tb_calc_alu_arbiter.sv
// Randomised bench for calc_alu_arbiter with a behavioural sticky-done ALU and a
// round-robin reference model.
module tb_calc_alu_arbiter;
    localparam int N  = 4;
    localparam int W  = 32;
    localparam int TO = 16;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req = '0;
    logic [3*N-1:0] req_op = '0;
    logic [W*N-1:0] req_a = '0;
    logic [W*N-1:0] req_b = '0;
    logic [N-1:0]   gnt, rsp_valid;
    logic [W-1:0]   rsp_result;
    logic           rsp_err, busy, alu_start;
    logic [2:0]     alu_op;
    logic [W-1:0]   alu_op1, alu_op2;
    logic           alu_done;
    logic [W-1:0]   alu_result;

    int n_vec = 0;
    int n_err = 0;
    bit alu_hang = 1'b0;
    int alu_cnt;
    int m_ptr = 0;

    logic [2:0] r_op [N];
    logic [W-1:0] r_a [N];
    logic [W-1:0] r_b [N];

    int gq[$], gcyc[$], rq_idx[$], rcyc[$], exp_q[$];
    logic [W-1:0] rq_res[$];
    logic rq_err[$];
    int starts;

    always #5 clk = ~clk;

    calc_alu_arbiter #(.NREQ(N), .WIDTH(W), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .req(req), .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .gnt(gnt), .rsp_valid(rsp_valid), .rsp_result(rsp_result), .rsp_err(rsp_err),
        .busy(busy), .alu_start(alu_start), .alu_op(alu_op), .alu_op1(alu_op1),
        .alu_op2(alu_op2), .alu_done(alu_done), .alu_result(alu_result)
    );

    function automatic logic [W-1:0] alu_fn(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a * b;
            3'd3: return (b == 0) ? '0 : a / b;
            3'd4: return (b == 0) ? '0 : a % b;
            3'd5: return a & b;
            3'd6: return a | b;
            default: return a ^ b;
        endcase
    endfunction

    function automatic bit is_div0(input logic [2:0] op, input logic [W-1:0] b);
`ifdef CALC_ARB_DIV0_CHECK_EN
        return ((op == 3'd3) || (op == 3'd4)) && (b == 0);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [W-1:0] exp_res(input int i);
        return is_div0(r_op[i], r_b[i]) ? '1 : alu_fn(r_op[i], r_a[i], r_b[i]);
    endfunction

    // ALU: sticky done, cleared on start, result two cycles after the last start.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_done <= 1'b0; alu_cnt <= 0; alu_result <= '0;
        end else if (alu_start) begin
            alu_done <= 1'b0; alu_cnt <= 2;
        end else if (alu_cnt != 0) begin
            alu_cnt <= alu_cnt - 1;
            if (alu_cnt == 1 && !alu_hang) begin
                alu_done <= 1'b1;
                alu_result <= alu_fn(alu_op, alu_op1, alu_op2);
            end
        end
    end

    task automatic set_req(input int i, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        r_op[i] = op; r_a[i] = a; r_b[i] = b;
        req_op[3*i +: 3] = op; req_a[W*i +: W] = a; req_b[W*i +: W] = b;
    endtask

    // Requesters hold req until their grant; collects grant and response events.
    task automatic serve(input int budget, output bit to);
        int cyc = 0;
        to = 1'b0;
        gq.delete(); gcyc.delete(); rq_idx.delete(); rcyc.delete(); rq_res.delete(); rq_err.delete();
        starts = 0;
        while (1) begin
            @(negedge clk);
            cyc++;
            if (alu_start) starts++;
            for (int i = 0; i < N; i++) begin
                if (gnt[i]) begin gq.push_back(i); gcyc.push_back(cyc); req[i] = 1'b0; end
                if (rsp_valid[i]) begin
                    rq_idx.push_back(i); rcyc.push_back(cyc); rq_res.push_back(rsp_result); rq_err.push_back(rsp_err);
                end
            end
            if (req == 0 && !busy) break;
            if (cyc >= budget) begin to = 1'b1; break; end
        end
    endtask

    // Round-robin reference: fills exp_q with the grant order and advances m_ptr.
    task automatic rr_model(input logic [N-1:0] mask);
        exp_q.delete();
        while (mask != 0) begin
            for (int k = 0; k < N; k++) begin
                int idx = (m_ptr + k) % N;
                if (mask[idx]) begin
                    exp_q.push_back(idx); mask[idx] = 1'b0; m_ptr = (idx + 1) % N;
                    break;
                end
            end
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk); rst = 1'b1; req = '0;
        @(negedge clk); rst = 1'b0; m_ptr = 0;
    endtask

    task automatic test_reset();
        bit got = 1'b0;
        int bad = 0;
        logic [2*N+3*W+6-1:0] all_out;
        repeat (2) @(negedge clk);
        all_out = {gnt, rsp_valid, rsp_result, rsp_err, busy, alu_start, alu_op, alu_op1, alu_op2};
        n_vec++;
        if (all_out !== '0) begin n_err++; $display("FAIL reset_outputs: got %h want 0", all_out); end
        rst = 1'b0; m_ptr = 0;
        set_req(0, 3'd0, 32'd1, 32'd2); req = 4'b0001;
        for (int c = 0; c < 10 && !got; c++) begin @(negedge clk); if (gnt[0]) got = 1'b1; end
        req = '0;
        n_vec++;
        if (!got) begin n_err++; $display("FAIL reset_pre_gnt: got no grant want gnt[0]"); end
        @(negedge clk);
        n_vec++;
        if (busy !== 1'b1 || alu_start !== 1'b0) begin
            n_err++; $display("FAIL reset_in_wait: busy=%b start=%b want 1 0", busy, alu_start);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        all_out = {gnt, rsp_valid, rsp_result, rsp_err, busy, alu_start, alu_op, alu_op1, alu_op2};
        n_vec++;
        if (all_out !== '0) begin n_err++; $display("FAIL reset_mid_wait: got %h want 0", all_out); end
        @(negedge clk); rst = 1'b0; m_ptr = 0;
        repeat (10) begin @(negedge clk); if (rsp_valid !== '0 || busy !== 1'b0) bad++; end
        n_vec++;
        if (bad != 0) begin n_err++; $display("FAIL reset_abort: %0d cycles with rsp/busy want 0", bad); end
    endtask

    task automatic test_single();
        bit to;
        set_req(0, 3'd0, 32'd5, 32'd7); req = 4'b0001;
        serve(40, to);
        m_ptr = 1;
        n_vec++;
        if (to || gq.size() != 1 || gq[0] != 0 || gcyc[0] != 1) begin
            n_err++; $display("FAIL single_gnt: count=%0d to=%0d want one gnt[0] one cycle after req", gq.size(), to);
        end
        n_vec++;
        if (rq_idx.size() != 1 || rq_idx[0] != 0 || rq_res[0] !== 32'd12 || rq_err[0] !== 1'b0) begin
            n_err++; $display("FAIL single_rsp: count=%0d res=%0d want one rsp[0] res=12 err=0", rq_idx.size(), (rq_res.size() > 0) ? rq_res[0] : 0);
        end else if (rcyc[0] - gcyc[0] < 3 || rcyc[0] - gcyc[0] > 6) begin
            n_err++; $display("FAIL single_latency: got %0d want 3..6", rcyc[0] - gcyc[0]);
        end
    endtask

    task automatic test_rr();
        bit to;
        int exp1[4] = '{0, 1, 2, 3};
        int exp2[3] = '{3, 0, 1};
        pulse_reset();
        for (int i = 0; i < N; i++) set_req(i, 3'($urandom_range(0, 7)), $urandom, $urandom);
        req = 4'b1111;
        serve(200, to);
        n_vec++;
        if (to || gq.size() != 4 || rq_idx.size() != 4) begin
            n_err++; $display("FAIL rr_all_count: gnts=%0d rsps=%0d want 4 4", gq.size(), rq_idx.size());
        end
        for (int i = 0; i < 4 && i < gq.size() && i < rq_idx.size(); i++) begin
            n_vec++;
            if (gq[i] != exp1[i] || rq_idx[i] != exp1[i] || rq_res[i] !== exp_res(exp1[i])) begin
                n_err++; $display("FAIL rr_all_%0d: gnt=%0d rsp=%0d res=%h want %0d res=%h", i, gq[i], rq_idx[i], rq_res[i], exp1[i], exp_res(exp1[i]));
            end
        end
        set_req(1, 3'd0, 32'd1, 32'd1); req = 4'b0010;
        serve(40, to);
        for (int i = 0; i < N; i++) set_req(i, 3'($urandom_range(0, 7)), $urandom, $urandom);
        req = 4'b1011;
        serve(200, to);
        m_ptr = 2;
        n_vec++;
        if (to || gq.size() != 3) begin
            n_err++; $display("FAIL rr_1011_count: got %0d want 3", gq.size());
        end
        for (int i = 0; i < 3 && i < gq.size() && i < rq_idx.size(); i++) begin
            n_vec++;
            if (gq[i] != exp2[i] || rq_idx[i] != exp2[i] || rq_res[i] !== exp_res(exp2[i])) begin
                n_err++; $display("FAIL rr_1011_%0d: gnt=%0d rsp=%0d want %0d", i, gq[i], rq_idx[i], exp2[i]);
            end
        end
    endtask

    task automatic test_sticky();
        bit to;
        logic [W-1:0] want [2] = '{32'd12, 32'd7};
        for (int t = 0; t < 2; t++) begin
            if (t == 0) set_req(1, 3'd2, 32'd3, 32'd4);
            else        set_req(1, 3'd1, 32'd10, 32'd3);
            req = 4'b0010;
            serve(40, to);
            n_vec++;
            if (to || rq_idx.size() != 1 || rq_idx[0] != 1 || rq_res[0] !== want[t] || rq_err[0] !== 1'b0) begin
                n_err++; $display("FAIL sticky_%0d: res=%0d want %0d", t, (rq_res.size() > 0) ? rq_res[0] : 0, want[t]);
            end
        end
        m_ptr = 2;
    endtask

    task automatic test_timeout();
        bit to;
        alu_hang = 1'b1;
        set_req(2, 3'd0, 32'd1, 32'd1); req = 4'b0100;
        serve(TO + 30, to);
        alu_hang = 1'b0;
        m_ptr = 3;
        n_vec++;
        if (to || rq_idx.size() != 1 || rq_idx[0] != 2 || rq_res[0] !== '0 || rq_err[0] !== 1'b1) begin
            n_err++; $display("FAIL timeout_rsp: to=%0d rsps=%0d want err=1 res=0 then idle", to, rq_idx.size());
        end else if (gcyc.size() != 1 || rcyc[0] - gcyc[0] < TO - 1 || rcyc[0] - gcyc[0] > TO + 2) begin
            n_err++; $display("FAIL timeout_latency: got %0d want about %0d", rcyc[0] - ((gcyc.size() > 0) ? gcyc[0] : 0), TO);
        end
    endtask

    task automatic test_div0();
        bit to;
        set_req(2, 3'b011, 32'd9, 32'd0); req = 4'b0100;
        serve(40, to);
        m_ptr = 3;
        n_vec++;
        if (to || gq.size() != 1 || gq[0] != 2 || rq_idx.size() != 1 || rq_idx[0] != 2) begin
            n_err++; $display("FAIL div0_handshake: gnts=%0d rsps=%0d want 1 1", gq.size(), rq_idx.size());
        end else if (rq_res[0] !== exp_res(2) || rq_err[0] !== is_div0(3'b011, 32'd0)) begin
            n_err++; $display("FAIL div0_result: res=%h err=%0d want %h %0d", rq_res[0], rq_err[0], exp_res(2), is_div0(3'b011, 32'd0));
        end
        n_vec++;
`ifdef CALC_ARB_DIV0_CHECK_EN
        if (starts != 0) begin n_err++; $display("FAIL div0_start: got %0d start cycles want 0", starts); end
`else
        if (starts == 0) begin n_err++; $display("FAIL div0_start: got 0 start cycles want >0"); end
`endif
    endtask

    task automatic test_random();
        bit to;
        logic [N-1:0] mask;
        for (int it = 0; it < 25; it++) begin
            mask = N'($urandom_range(1, (1 << N) - 1));
            for (int i = 0; i < N; i++)
                set_req(i, 3'($urandom_range(0, 7)), $urandom,
                        ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom));
            rr_model(mask);
            req = mask;
            serve(300, to);
            n_vec++;
            if (to || gq.size() != exp_q.size() || rq_idx.size() != exp_q.size()) begin
                n_err++; $display("FAIL rand_%0d_count: mask=%b gnts=%0d rsps=%0d want %0d", it, mask, gq.size(), rq_idx.size(), exp_q.size());
            end
            for (int i = 0; i < exp_q.size() && i < gq.size() && i < rq_idx.size(); i++) begin
                n_vec++;
                if (gq[i] != exp_q[i] || rq_idx[i] != exp_q[i] || rq_res[i] !== exp_res(exp_q[i]) ||
                    rq_err[i] !== is_div0(r_op[exp_q[i]], r_b[exp_q[i]])) begin
                    n_err++; $display("FAIL rand_%0d_%0d: gnt=%0d rsp=%0d res=%h err=%0d want %0d res=%h", it, i,
                                      gq[i], rq_idx[i], rq_res[i], rq_err[i], exp_q[i], exp_res(exp_q[i]));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_rr();
        test_sticky();
        test_timeout();
        test_div0();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
